program_counter: RTL
====================

# program_counter

Instruction-fetch program counter for the accumulator core, directly downstream of the ALU. It consumes the ALU's `ConditionalBranch` and the 5-bit immediate field and produces the next instruction address for instruction memory. Branch targets come from an internal 32-entry lookup table (LUT) indexed by the immediate. A small state machine sequences start, run, stall and halt, and counts retired instructions.

## Interface
- `PC_W`, 10, program counter and LUT entry width
- `CNT_W`, 16, retired-instruction counter width
- `Clk`  in  1  rising-edge clock
- `ResetN`  in  1  asynchronous, active-low reset
- `Start`  in  1  begin execution at `StartAddr`; honoured in IDLE/HALTED only
- `StartAddr`  in  PC_W  first instruction address
- `Stall`  in  1  current instruction not complete; freeze PC
- `Halt`  in  1  decoded halt instruction at current `Pc`
- `ConditionalBranch`  in  1  branch taken, from ALU
- `ImmediateIn`  in  5  LUT index, from instruction immediate field
- `LutWe`  in  1  LUT write enable
- `LutAddr`  in  5  LUT write index
- `LutData`  in  PC_W  LUT write data
- `Pc`  out  PC_W  current instruction address
- `Running`  out  1  high in RUN
- `Done`  out  1  high in HALTED
- `InstrCount`  out  CNT_W  retired instructions since last Start

## Operation
- States: IDLE, RUN, HALTED. Reset state is IDLE.
- IDLE/HALTED with `Start`=1: `Pc`<=`StartAddr`, `InstrCount`<=0, go to RUN. All other inputs are ignored.
- RUN priority: `Stall` > `Halt` > `ConditionalBranch` > increment. `Start` is ignored.
  - `Stall`=1: `Pc` and `InstrCount` hold. `Halt` and branch are deferred until `Stall` drops.
  - `Halt`=1: go to HALTED; `Pc` holds; `InstrCount`+1.
  - `ConditionalBranch`=1: `Pc`<=target; `InstrCount`+1.
  - Otherwise: `Pc`<=`Pc`+1, modulo 2^PC_W (max address wraps to 0); `InstrCount`+1.
- Target is `Lut[ImmediateIn]`; see Configuration for how it is applied.
- `InstrCount` saturates at 2^CNT_W-1 and does not wrap.
- LUT:
  - 32 x PC_W registers, written on `LutWe` in any state.
  - Read is combinational. A same-cycle write to the index being read returns the old value.
- `ConditionalBranch`, `Halt` and `Stall` are ignored outside RUN.

## Timing
- All state, `Pc`, `InstrCount` and LUT update on the rising `Clk` edge. Outputs are registered or decoded directly from state.
- Reset values: `Pc`=0, `InstrCount`=0, `Running`=0, `Done`=0, all LUT entries 0.
- Latency: a decision made in cycle N shows on `Pc` in cycle N+1. The ALU must present `ConditionalBranch` for the instruction at `Pc` in the same cycle.
- `Start` to RUN: one edge. `Running`=1 and `Pc`=`StartAddr` in the following cycle.
- `Halt` to `Done`: one edge. `Done` stays high until the `Start` edge, then drops in the same cycle that `Running` rises.
- `ResetN` low mid-operation: immediate return to reset values, including the LUT, independent of `Clk`.

## Configuration
- `PC_BRANCH_RELATIVE_EN` defined:
  - Each LUT entry is a signed two's-complement offset.
  - Target = `Pc` + `Lut[ImmediateIn]`, truncated to PC_W (wraps both directions).
- Not defined:
  - Each LUT entry is an absolute address.
  - Target = `Lut[ImmediateIn]`.

## Test plan
- Reset, then `Start`=1 with `StartAddr`=5, then 4 free-running cycles -> `Pc` sequence 5,6,7,8,9; `InstrCount`=4; `Running`=1.
- `Lut[3]`=40 (absolute build), `Pc`=9, `ImmediateIn`=3, `ConditionalBranch`=1 -> next `Pc`=40. Relative build with `Lut[3]`=0x3FE (-2) -> next `Pc`=7.
- `Stall`=1 for 3 cycles with `Halt`=1 and `ConditionalBranch`=1 -> `Pc` and `InstrCount` frozen. `Stall` drops -> HALTED, `Done`=1, `Pc` unchanged.
- `Pc`=1023 with no branch -> `Pc`=0. Relative build, `Pc`=1, offset -3 -> `Pc`=1022.
- `Start` pulsed in RUN -> ignored. `Start` in HALTED with `StartAddr`=0 -> `Pc`=0, `InstrCount`=0, `Done`=0, `Running`=1.
- `ResetN` driven low mid-run between clock edges, with `Pc`=17 -> `Pc`=0, IDLE, and `Lut[3]` reads 0 immediately.

Source files
------------

// File: rtl/program_counter_if.sv
// Instruction-fetch bus between the core control/ALU and the program counter.
// The master drives control, ALU and LUT-write signals; the slave returns Pc and status.
interface program_counter_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  // Start, Stall, Halt, ConditionalBranch and LutWe are single-cycle level
  // qualifiers sampled on the rising Clk edge; there is no ready back-pressure.
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             Stall;
  logic             Halt;
  logic             ConditionalBranch;
  logic [4:0]       ImmediateIn;
  logic             LutWe;
  logic [4:0]       LutAddr;
  logic [PC_W-1:0]  LutData;
  logic [PC_W-1:0]  Pc;
  logic             Running;
  logic             Done;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    output Start, StartAddr, Stall, Halt, ConditionalBranch, ImmediateIn,
           LutWe, LutAddr, LutData,
    input  Pc, Running, Done, InstrCount
  );

  modport slave (
    input  Start, StartAddr, Stall, Halt, ConditionalBranch, ImmediateIn,
           LutWe, LutAddr, LutData,
    output Pc, Running, Done, InstrCount
  );
endinterface

// File: rtl/program_counter.sv
// Program counter with 32-entry branch-target LUT, IDLE/RUN/HALTED sequencing and a
// saturating retired-instruction counter. Define PC_BRANCH_RELATIVE_EN for Pc-relative targets.
module program_counter #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic                Clk,
  input  logic                ResetN,
  program_counter_if.slave    bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_sat;
  logic [PC_W-1:0]  r_lut [32];
  logic [PC_W-1:0]  w_lut_rd;
  logic [PC_W-1:0]  w_target;

  // Reading the register array directly gives the pre-write value on a same-cycle write.
  assign w_lut_rd = r_lut[bus.ImmediateIn];

`ifdef PC_BRANCH_RELATIVE_EN
  assign w_target = r_pc + w_lut_rd;
`else
  assign w_target = w_lut_rd;
`endif

  assign w_cnt_sat = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_ONE;

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      S_IDLE, S_HALTED: begin
        if (bus.Start) begin
          w_next_state = S_RUN;
          w_pc_next    = bus.StartAddr;
          w_cnt_next   = '0;
        end
      end
      S_RUN: begin
        // Stall freezes everything, deferring Halt and branch until it drops.
        if (!bus.Stall) begin
          w_cnt_next = w_cnt_sat;
          if (bus.Halt) begin
            w_next_state = S_HALTED;
          end else if (bus.ConditionalBranch) begin
            w_pc_next = w_target;
          end else begin
            w_pc_next = r_pc + PC_ONE;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 32; i++) begin
        r_lut[i] <= '0;
      end
    end else if (bus.LutWe) begin
      r_lut[bus.LutAddr] <= bus.LutData;
    end
  end

  assign bus.Pc         = r_pc;
  assign bus.InstrCount = r_cnt;
  assign bus.Running    = (r_state == S_RUN);
  assign bus.Done       = (r_state == S_HALTED);
  assign o_dbg_state    = r_state;

endmodule
